// File: rtl/regfile_pkg.sv
// Package: regfile_pkg
// Shared types and constants for the 32x32 register file write path.
// - REG_ADDR_W / REG_DATA_W : register address and data widths
// - REG_ZERO                : hard-wired zero register; writes to it are discarded
// - rf_wr_req_t             : one queued writeback request {addr, data}
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Module: regfile_wr_fifo
// Generic DEPTH-entry synchronous FIFO of rf_wr_req_t.
// Ports:
// - clk, rst_n   : clock, synchronous active-low reset (pointers and count only)
// - push/wr_req  : enqueue wr_req at the tail (caller guarantees not full)
// - pop          : drop the head entry (caller guarantees not empty)
// - count        : occupied entries, 0..DEPTH
// - entries      : all slots in age order, entries[0] = head (oldest)
// - entry_valid  : entry_valid[i] = entries[i] holds queued data
module regfile_wr_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  rf_wr_req_t       wr_req,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output rf_wr_req_t       entries [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  rf_wr_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and count, so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_req;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = count_q;

  // Age-ordered view lets the consumer pick the youngest match by scanning
  // upward and keeping the last hit.
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    assign entries[i]     = mem[rd_ptr + PTR_W'(i)];
    assign entry_valid[i] = (CNT_W'(i) < count_q);
  end

endmodule

// File: rtl/regfile_write_queue.sv
// Module: regfile_write_queue
// Writeback queue in front of the register file write port (A3/WD3/WE3).
// Buffers datapath results and drains one per cycle whenever drain_en is high.
// Optional feature macro: REGFILE_WQ_FWD_EN (read-after-write lookup of
// still-queued data). Without it fwd_hit/fwd_data are tied to zero.
// Ports:
// - clk, rst_n                  : clock, synchronous active-low reset
// - in_valid/in_ready           : request handshake; in_addr/in_data payload
// - drain_en                    : register file write port free this cycle
// - A3/WD3/WE3                  : register file write port
// - count                       : occupied entries
// - fwd_addr/fwd_hit/fwd_data   : forwarding lookup
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = REG_DATA_W,
  parameter  int ADDR_W = REG_ADDR_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  rf_wr_req_t       entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic             push;
  logic             live;

  // Full refuses even when a pop happens this cycle: in_ready looks only at
  // the registered count, keeping it off any combinational path from drain_en.
  assign in_ready = (count != CNT_W'(DEPTH));

  // Writes to the zero register complete the handshake but are dropped here.
  assign push = in_valid && in_ready && (in_addr != REG_ZERO);

  // Outputs are forced quiet while reset is asserted, even before the
  // first reset edge has cleared the count.
  assign live = rst_n && (count != '0);
  assign WE3  = live && drain_en;
  assign A3   = live ? entries[0].addr : '0;
  assign WD3  = live ? entries[0].data : '0;

  regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .wr_req      ('{addr: in_addr, data: in_data}),
    .pop         (WE3),
    .count       (count),
    .entries     (entries),
    .entry_valid (entry_valid)
  );

`ifdef REGFILE_WQ_FWD_EN
  // Scan oldest to youngest so the last hit is the newest write. The head
  // is still searched in the cycle it pops.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rst_n && entry_valid[i] && (fwd_addr != REG_ZERO) &&
          (entries[i].addr == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[i].data;
      end
    end
  end
`else
  logic unused_fwd;

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;

  always_comb begin
    unused_fwd = ^fwd_addr ^ ^entry_valid;
    for (int i = 1; i < DEPTH; i++) unused_fwd = unused_fwd ^ ^entries[i];
  end
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Testbench: tb_regfile_write_queue
// Scoreboard bench for regfile_write_queue. The stimulus pushes each accepted
// non-zero write into sb_q; the monitor pops sb_q whenever WE3 is seen.
// A queue-level model (mdl_q) predicts occupancy, WE3 and forwarding.
// Honours REGFILE_WQ_FWD_EN the same way the design does.
module tb_regfile_write_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [2:0]  count;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int total = 0;
  int bad   = 0;

  rf_wr_req_t  sb_q [$];
  rf_wr_req_t  mdl_q [$];
  logic [31:0] rf [32];
  bit          rst_seen = 1'b0;

  regfile_write_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .A3       (A3),
    .WD3      (WD3),
    .WE3      (WE3),
    .count    (count),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; record the write the spec says must emerge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic dr, input logic [4:0] fa);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    drain_en = dr;
    fwd_addr = fa;
    if (rst_n && v && mdl_q.size() != DEPTH && a != 5'd0)
      sb_q.push_back('{addr: a, data: d});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step(1'b1, 5'd9, 32'd99, 1'b1, 5'd9);
    rst_n = 1'b1;
  endtask

  // Monitor + model: compare at the falling edge, then advance the model
  // to what the next rising edge will do.
  always @(negedge clk) begin
    logic        exp_we;
    logic        exp_hit;
    logic [31:0] exp_fd;
    rf_wr_req_t  e;
    if (!rst_n) begin
      check("we3_in_reset", {63'd0, WE3}, 64'd0);
      check("a3_in_reset", {59'd0, A3}, 64'd0);
      check("wd3_in_reset", {32'd0, WD3}, 64'd0);
      check("fwd_hit_in_reset", {63'd0, fwd_hit}, 64'd0);
      check("fwd_data_in_reset", {32'd0, fwd_data}, 64'd0);
      if (rst_seen) begin
        check("count_in_reset", {61'd0, count}, 64'd0);
        check("in_ready_in_reset", {63'd0, in_ready}, 64'd1);
      end
      rst_seen = 1'b1;
      mdl_q.delete();
      sb_q.delete();
    end else begin
      rst_seen = 1'b0;
      exp_we = (mdl_q.size() != 0) && drain_en;
      check("count", {61'd0, count}, 64'(mdl_q.size()));
      check("in_ready", {63'd0, in_ready}, {63'd0, mdl_q.size() != DEPTH});
      check("we3", {63'd0, WE3}, {63'd0, exp_we});
      if (!WE3) begin
        check("a3_idle", {59'd0, A3}, (mdl_q.size() != 0) ? 64'(mdl_q[0].addr) : 64'd0);
      end else if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL write_unexpected: got A3=%0d WD3=%0d expected no write", A3, WD3);
      end else begin
        e = sb_q.pop_front();
        check("a3", {59'd0, A3}, 64'(e.addr));
        check("wd3", {32'd0, WD3}, 64'(e.data));
        rf[A3] = WD3;
      end
      exp_hit = 1'b0;
      exp_fd  = '0;
`ifdef REGFILE_WQ_FWD_EN
      if (fwd_addr != 5'd0) begin
        foreach (mdl_q[i]) begin
          if (mdl_q[i].addr == fwd_addr) begin
            exp_hit = 1'b1;
            exp_fd  = mdl_q[i].data;
          end
        end
      end
`endif
      check("fwd_hit", {63'd0, fwd_hit}, {63'd0, exp_hit});
      check("fwd_data", {32'd0, fwd_data}, {32'd0, exp_fd});
      // Model update for the coming edge: pop first, refuse when full.
      if (in_valid && mdl_q.size() != DEPTH && in_addr != 5'd0) begin
        if (exp_we) void'(mdl_q.pop_front());
        mdl_q.push_back('{addr: in_addr, data: in_data});
      end else if (exp_we) begin
        void'(mdl_q.pop_front());
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 32'd99;
    drain_en = 1'b1;
    fwd_addr = 5'd0;
    foreach (rf[i]) rf[i] = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // A write queued just before reset must never reach the register file.
    step(1'b1, 5'd9, 32'd99, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd9);
    do_reset(2);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);

    // Single write lands in register 2.
    step(1'b1, 5'd2, 32'd40, 1'b1, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("rf_r2", {32'd0, rf[2]}, 64'd40);

    // Fill and backpressure: fifth request refused.
    step(1'b1, 5'd4, 32'd80, 1'b0, 5'd0);
    step(1'b1, 5'd8, 32'd160, 1'b0, 5'd0);
    step(1'b1, 5'd16, 32'd320, 1'b0, 5'd0);
    step(1'b1, 5'd31, 32'd640, 1'b0, 5'd0);
    step(1'b1, 5'd3, 32'd7, 1'b0, 5'd0);
    check("full_count", {61'd0, count}, 64'd4);
    check("full_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("rf_r31", {32'd0, rf[31]}, 64'd640);
    check("rf_r3_untouched", {32'd0, rf[3]}, 64'd0);

    // Zero register: handshake completes, nothing queued.
    step(1'b1, 5'd0, 32'd20, 1'b1, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("zero_count", {61'd0, count}, 64'd0);

    // Simultaneous push and pop at count=2.
    step(1'b1, 5'd5, 32'd1, 1'b0, 5'd0);
    step(1'b1, 5'd6, 32'd2, 1'b0, 5'd0);
    step(1'b1, 5'd7, 32'd3, 1'b1, 5'd0);
    check("simul_count", {61'd0, count}, 64'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);

    // Forwarding: youngest of two writes to r8; misses on r0 and r12.
    step(1'b1, 5'd8, 32'd160, 1'b0, 5'd0);
    step(1'b1, 5'd8, 32'd161, 1'b0, 5'd8);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd8);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd12);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8);

    // Randomised traffic with occasional mid-stream resets.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] fa;
      if ($urandom_range(0, 99) == 0) do_reset(1);
      fa = (mdl_q.size() != 0 && $urandom_range(0, 1) == 1)
           ? mdl_q[$urandom_range(0, mdl_q.size() - 1)].addr
           : 5'($urandom_range(0, 31));
      step($urandom_range(0, 9) < 7,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom, $urandom_range(0, 9) < 6, fa);
    end

    // Bounded drain; anything left in the scoreboard never came out.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check("drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
